dct_pass_sequencer: RTL and testbench
=====================================

Name: dct_pass_sequencer

Overview:
- Sequences one 2-D forward transform on the DCT kernel as two passes: a row pass, then a column pass.
- Each pass issues N 1-D vector jobs, where N = 2^size_log2, to the 1-D kernel datapath.
- Tracks in-flight jobs with a credit counter and reports busy/done/error/irq to the AXI4-Lite control register bank.
- Sits between the control/status registers and the kernel plus transpose-buffer address logic.

Parameters:
MAX_LOG2, 5, largest supported transform size log2 (32x32); minimum supported is 2 (4x4)
OUTST, 4, maximum kernel jobs in flight (credit limit), must be >= 1
CNT_W, 3, width of the outstanding counter; must hold 0..OUTST

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESET  in  1  asynchronous reset, active-high
cfg_start  in  1  one-cycle start pulse from control register
cfg_size_log2  in  3  transform size log2, sampled with cfg_start
cfg_abort  in  1  one-cycle abort pulse
cfg_irq_clr  in  1  clears irq
vec_valid  out  1  job request to kernel
vec_ready  in  1  kernel accepts job
vec_idx  out  MAX_LOG2  row/column index of the job
vec_dir  out  1  0 = row pass, 1 = column pass
vec_len_log2  out  3  latched size for the kernel
res_valid  in  1  one kernel job completed (one pulse per job)
stat_busy  out  1  high in any state other than IDLE and ERR
stat_pass  out  1  current pass, 0 = row, 1 = column
stat_done  out  1  one-cycle pulse on successful completion
stat_err  out  1  sticky error flag
irq  out  1  sticky; set on done or error, cleared by cfg_irq_clr or start

Behaviour:
- Reset (async, ARESET=1): state=IDLE; all outputs 0; counters 0; latched size 0.
- States: IDLE, ROW_ISS, ROW_DRN, COL_ISS, COL_DRN, DONE, ABRT, ERR.
- IDLE or ERR, cfg_start=1:
  - Size in 2..MAX_LOG2: latch size, clear stat_err and irq, issued=0, go ROW_ISS. vec_valid is high in the next cycle, i.e. one cycle after start.
  - Size out of range: go/stay ERR, set stat_err and irq.
- cfg_start while busy is ignored; it has no effect and is not an error.
- Issue rule (ROW_ISS/COL_ISS):
  - vec_valid = (issued < N) && (outstanding < OUTST).
  - vec_idx = issued; vec_dir = pass.
  - Once valid is asserted, idx, dir and len remain stable until the vec_valid && vec_ready handshake.
  - On handshake, issued increments.
  - When issued reaches N, move to the matching DRN state.
- outstanding counter:
  - +1 on handshake, -1 on res_valid.
  - Both in the same cycle: unchanged.
  - Never exceeds OUTST.
- Drain: in ROW_DRN or COL_DRN, when outstanding==0 (including a res_valid that decrements it to 0 this cycle), the next state is COL_ISS (issued cleared, stat_pass=1) or DONE respectively.
  - Results received during the issue states count normally.
- DONE: lasts one cycle; stat_done=1, irq set; then IDLE. stat_pass returns to 0 in IDLE.
- Spurious result: res_valid with outstanding==0 in any state (including IDLE) goes to ERR, sets stat_err and irq; the counter stays 0.
- Abort: cfg_abort in any busy state goes to ABRT.
  - vec_valid is deasserted the next cycle, even if a handshake was pending.
  - ABRT waits for outstanding==0, then goes to IDLE with no done and no error.
  - cfg_abort in IDLE or ERR is ignored.
- cfg_abort and res_valid in the same cycle: the decrement still applies.
- irq: set on DONE entry or ERR entry; cleared by cfg_irq_clr. Set has priority over clear in the same cycle.
- ARESET mid-operation returns everything to reset values immediately. Results from the kernel arriving after reset count as spurious only if the kernel itself was not reset (system requirement: both blocks share ARESET).

Test Plan:
- size=3, vec_ready=1, res_valid 3 cycles after each handshake, OUTST=4 -> row idx 0..7 with dir=0, then col idx 0..7 with dir=1; never more than 4 outstanding; exactly 16 handshakes; one stat_done pulse; irq=1.
- size=2 with vec_ready toggling 1-of-3 cycles -> vec_idx/dir stable while valid and not ready; 4+4 jobs; done pulse.
- cfg_start with size=6 (MAX_LOG2=5) -> ERR, stat_err=1, irq=1, no vec_valid; then start with size=2 -> stat_err cleared, normal completion.
- res_valid pulse in IDLE -> ERR, stat_err=1; cfg_irq_clr -> irq=0, stat_err remains 1.
- size=4, abort after 5 row handshakes with 2 in flight -> vec_valid=0 next cycle; IDLE after 2 res_valid pulses; stat_done never pulses.
- ARESET asserted mid-column-pass -> all outputs 0 asynchronously; after release, a new start completes a full 4x4 sequence.

Source files
------------

// File: rtl/dct_pass_sequencer.sv
// Row-then-column pass sequencer for the 2-D DCT: issues N 1-D jobs per pass to the
// kernel, limits in-flight jobs by credit, and reports busy/done/error/irq status.
module dct_pass_sequencer #(
  parameter int MAX_LOG2 = 5,
  parameter int OUTST    = 4,
  parameter int CNT_W    = 3
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cfg_start,
  input  logic [2:0]          cfg_size_log2,
  input  logic                cfg_abort,
  input  logic                cfg_irq_clr,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic [MAX_LOG2-1:0] vec_idx,
  output logic                vec_dir,
  output logic [2:0]          vec_len_log2,
  input  logic                res_valid,
  output logic                stat_busy,
  output logic                stat_pass,
  output logic                stat_done,
  output logic                stat_err,
  output logic                irq
);

  localparam int               ISS_W   = MAX_LOG2 + 1;
  localparam logic [2:0]       MAX_SZ  = 3'(MAX_LOG2);
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(OUTST);
  localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_1   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ISS_W-1:0] ISS_0   = {ISS_W{1'b0}};
  localparam logic [ISS_W-1:0] ISS_1   = {{(ISS_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ROW_ISS = 3'd1,
    S_ROW_DRN = 3'd2,
    S_COL_ISS = 3'd3,
    S_COL_DRN = 3'd4,
    S_DONE    = 3'd5,
    S_ABRT    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [ISS_W-1:0] issued_r, issued_s, n_r_s, n_next_s;
  logic [CNT_W-1:0] outst_r, outst_s;
  logic [2:0]       size_r, size_s;
  logic             pass_r, pass_s, err_r, err_s, irq_r, irq_s;
  logic             valid_r, valid_s, busy_r, done_r;
  logic [MAX_LOG2-1:0] idx_r;
  logic             hs_s, dec_s, spur_s, size_ok_s, busy_now_s;

  assign n_r_s = ISS_1 << size_r;

  // Next-state, counter and flag computation; outputs are registered from these values
  always_comb begin
    hs_s       = valid_r && vec_ready;
    dec_s      = res_valid && (outst_r != CNT_0);
    spur_s     = res_valid && (outst_r == CNT_0);
    size_ok_s  = (cfg_size_log2 >= 3'd2) && (cfg_size_log2 <= MAX_SZ);
    busy_now_s = (state_r != S_IDLE) && (state_r != S_ERR);
    state_s    = state_r;
    issued_s   = issued_r;
    size_s     = size_r;
    pass_s     = pass_r;
    err_s      = err_r;

    if (hs_s && !dec_s) begin
      outst_s = outst_r + CNT_1;
    end else if (!hs_s && dec_s) begin
      outst_s = outst_r - CNT_1;
    end else begin
      outst_s = outst_r;
    end

    if (cfg_irq_clr) begin
      irq_s = 1'b0;
    end else begin
      irq_s = irq_r;
    end

    case (state_r)
      S_IDLE, S_ERR: begin
        if (cfg_start && size_ok_s) begin
          state_s  = S_ROW_ISS;
          size_s   = cfg_size_log2;
          issued_s = ISS_0;
          pass_s   = 1'b0;
          err_s    = 1'b0;
          irq_s    = 1'b0;
        end else if (cfg_start) begin
          state_s = S_ERR;
          err_s   = 1'b1;
          irq_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_ROW_ISS, S_COL_ISS: begin
        issued_s = issued_r + (hs_s ? ISS_1 : ISS_0);
        if (issued_s == n_r_s) begin
          state_s = (state_r == S_ROW_ISS) ? S_ROW_DRN : S_COL_DRN;
        end else begin
          state_s = state_r;
        end
      end
      S_ROW_DRN: begin
        if (outst_s == CNT_0) begin
          state_s  = S_COL_ISS;
          issued_s = ISS_0;
          pass_s   = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_COL_DRN: begin
        if (outst_s == CNT_0) begin
          state_s = S_DONE;
        end else begin
          state_s = state_r;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        pass_s  = 1'b0;
      end
      S_ABRT: begin
        if (outst_s == CNT_0) begin
          state_s = S_IDLE;
          pass_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // A result with nothing in flight outranks abort and normal sequencing
    if (spur_s) begin
      state_s = S_ERR;
      pass_s  = 1'b0;
      err_s   = 1'b1;
      irq_s   = 1'b1;
    end else if (cfg_abort && busy_now_s) begin
      state_s = S_ABRT;
    end else begin
      state_s = state_s;
    end

    if ((state_s == S_DONE) && (state_r != S_DONE)) begin
      irq_s = 1'b1;
    end else begin
      irq_s = irq_s;
    end

    n_next_s = ISS_1 << size_s;
    valid_s  = ((state_s == S_ROW_ISS) || (state_s == S_COL_ISS)) &&
               (issued_s < n_next_s) && (outst_s < CREDITS);
  end

  // State and registered outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r  <= S_IDLE;
      issued_r <= ISS_0;
      outst_r  <= CNT_0;
      size_r   <= 3'd0;
      pass_r   <= 1'b0;
      err_r    <= 1'b0;
      irq_r    <= 1'b0;
      valid_r  <= 1'b0;
      idx_r    <= {MAX_LOG2{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      issued_r <= issued_s;
      outst_r  <= outst_s;
      size_r   <= size_s;
      pass_r   <= pass_s;
      err_r    <= err_s;
      irq_r    <= irq_s;
      valid_r  <= valid_s;
      idx_r    <= issued_s[MAX_LOG2-1:0];
      busy_r   <= (state_s != S_IDLE) && (state_s != S_ERR);
      done_r   <= (state_s == S_DONE);
    end
  end

  assign vec_valid    = valid_r;
  assign vec_idx      = idx_r;
  assign vec_dir      = pass_r;
  assign vec_len_log2 = size_r;
  assign stat_busy    = busy_r;
  assign stat_pass    = pass_r;
  assign stat_done    = done_r;
  assign stat_err     = err_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_dct_pass_sequencer.sv
// Bench for dct_pass_sequencer: random ready/latency kernel model, job-order scoreboard,
// error, abort and reset scenarios.
module tb_dct_pass_sequencer;

  localparam int OUTST = 4;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       cfg_start, cfg_abort, cfg_irq_clr;
  logic [2:0] cfg_size_log2;
  logic       vec_valid, vec_ready, vec_dir;
  logic [4:0] vec_idx;
  logic [2:0] vec_len_log2;
  logic       res_valid;
  logic       stat_busy, stat_pass, stat_done, stat_err, irq;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int model_out = 0;
  int max_out = 0;
  int last_due = 0;
  int lat_min = 3;
  int lat_max = 3;
  int done_cnt, unstable, valid_seen;
  int due_q[$];
  int hs_idx_q[$];
  bit hs_dir_q[$];
  int hs_out_q[$];

  dct_pass_sequencer dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_start(cfg_start), .cfg_size_log2(cfg_size_log2),
    .cfg_abort(cfg_abort), .cfg_irq_clr(cfg_irq_clr),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_idx(vec_idx),
    .vec_dir(vec_dir), .vec_len_log2(vec_len_log2), .res_valid(res_valid),
    .stat_busy(stat_busy), .stat_pass(stat_pass), .stat_done(stat_done),
    .stat_err(stat_err), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock of stimulus from a negedge to the next; also acts as the kernel model
  task automatic step(input bit rdy, input bit st, input logic [2:0] sz,
                      input bit ab, input bit clr, input bit fres);
    bit res, hs, pend;
    int d;
    logic [4:0] p_idx;
    logic p_dir;
    logic [2:0] p_len;
    res = fres || (due_q.size() > 0 && due_q[0] <= cyc);
    hs  = (vec_valid === 1'b1) && rdy;
    vec_ready = rdy; cfg_start = st; cfg_size_log2 = sz;
    cfg_abort = ab; cfg_irq_clr = clr; res_valid = res;
    if (hs) begin
      hs_idx_q.push_back(int'(vec_idx));
      hs_dir_q.push_back(vec_dir);
      hs_out_q.push_back(model_out);
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      due_q.push_back(d);
    end
    if (res && !fres) void'(due_q.pop_front());
    model_out = model_out + (hs ? 1 : 0) - ((res && !fres) ? 1 : 0);
    if (model_out > max_out) max_out = model_out;
    pend  = (vec_valid === 1'b1) && !rdy && !ab;
    p_idx = vec_idx; p_dir = vec_dir; p_len = vec_len_log2;
    @(posedge ACLK);
    cyc++;
    @(negedge ACLK);
    if (pend && (vec_valid !== 1'b1 || vec_idx !== p_idx || vec_dir !== p_dir ||
                 vec_len_log2 !== p_len)) unstable++;
    if (stat_done === 1'b1) done_cnt++;
    if (vec_valid === 1'b1) valid_seen++;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_irq_clr = 1'b0; res_valid = 1'b0;
  endtask

  task automatic clear_logs();
    hs_idx_q.delete(); hs_dir_q.delete(); hs_out_q.delete();
    done_cnt = 0; unstable = 0; max_out = 0; valid_seen = 0;
  endtask

  // Full 2-D transform; mode 0 ready always, 1 ready one-of-three, 2 random
  task automatic run_seq(input string name, input logic [2:0] sz, input int mode, input bit stray);
    int n, tail, col_first;
    bit rdy, exp_dir;
    n = 1 << sz;
    tail = 0;
    clear_logs();
    step(1'b0, 1'b1, sz, 1'b0, 1'b0, 1'b0);
    total++;
    if (vec_valid !== 1'b1 || stat_busy !== 1'b1 || stat_err !== 1'b0 || irq !== 1'b0 ||
        vec_len_log2 !== sz) begin
      bad++;
      $display("FAIL %s_start: valid=%b busy=%b err=%b irq=%b len=%0d, required 1 1 0 0 %0d",
               name, vec_valid, stat_busy, stat_err, irq, vec_len_log2, sz);
    end
    for (int i = 0; i < 3000 && !(done_cnt > 0 && tail >= 3); i++) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      step(rdy, stray && (i == 7), 3'd7, 1'b0, 1'b0, 1'b0);
      if (done_cnt > 0) tail++;
    end
    total++;
    if (hs_idx_q.size() !== 2 * n) begin
      bad++;
      $display("FAIL %s_hs_count: got %0d, required %0d", name, hs_idx_q.size(), 2 * n);
    end
    col_first = -1;
    for (int i = 0; i < hs_idx_q.size() && i < 2 * n; i++) begin
      exp_dir = (i >= n);
      if (exp_dir && col_first < 0) col_first = hs_out_q[i];
      total++;
      if (hs_idx_q[i] !== (i % n) || hs_dir_q[i] !== exp_dir) begin
        bad++;
        $display("FAIL %s_job%0d: idx=%0d dir=%0d, required idx=%0d dir=%0d",
                 name, i, hs_idx_q[i], hs_dir_q[i], i % n, exp_dir);
      end
    end
    total++;
    if (col_first !== 0) begin
      bad++;
      $display("FAIL %s_col_after_drain: in flight at first column job %0d, required 0", name, col_first);
    end
    total++;
    if (max_out > OUTST) begin
      bad++;
      $display("FAIL %s_credit: max in flight %0d, limit %0d", name, max_out, OUTST);
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL %s_stable: %0d stalled jobs changed, required 0", name, unstable);
    end
    total++;
    if (done_cnt !== 1 || irq !== 1'b1 || stat_busy !== 1'b0 || stat_pass !== 1'b0 ||
        stat_err !== 1'b0 || model_out !== 0) begin
      bad++;
      $display("FAIL %s_end: done=%0d irq=%b busy=%b pass=%b err=%b out=%0d, required 1 1 0 0 0 0",
               name, done_cnt, irq, stat_busy, stat_pass, stat_err, model_out);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    vec_ready = 1'b0; cfg_start = 1'b0; cfg_size_log2 = 3'd0; cfg_abort = 1'b0;
    cfg_irq_clr = 1'b0; res_valid = 1'b0;
    #12;
    total++;
    if ({vec_valid, vec_idx, vec_dir, vec_len_log2, stat_busy, stat_pass, stat_done, stat_err, irq} !== 15'd0) begin
      bad++;
      $display("FAIL reset: outputs %b, required all 0",
               {vec_valid, vec_idx, vec_dir, vec_len_log2, stat_busy, stat_pass, stat_done, stat_err, irq});
    end
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic test_basic();
    lat_min = 3; lat_max = 3;
    run_seq("basic8", 3'd3, 0, 1'b0);
  endtask

  task automatic test_ready_toggle();
    lat_min = 1; lat_max = 4;
    run_seq("toggle4", 3'd2, 1, 1'b0);
  endtask

  task automatic test_bad_size();
    clear_logs();
    step(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (stat_err !== 1'b1 || irq !== 1'b1 || stat_busy !== 1'b0 || valid_seen !== 0) begin
      bad++;
      $display("FAIL bad_size: err=%b irq=%b busy=%b valid_cycles=%0d, required 1 1 0 0",
               stat_err, irq, stat_busy, valid_seen);
    end
    lat_min = 1; lat_max = 3;
    run_seq("after_err", 3'd2, 0, 1'b0);
  endtask

  task automatic test_spurious();
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    total++;
    if (stat_err !== 1'b1 || irq !== 1'b1 || stat_busy !== 1'b0) begin
      bad++;
      $display("FAIL spurious: err=%b irq=%b busy=%b, required 1 1 0", stat_err, irq, stat_busy);
    end
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    total++;
    if (irq !== 1'b0 || stat_err !== 1'b1) begin
      bad++;
      $display("FAIL irq_clr: irq=%b err=%b, required 0 1", irq, stat_err);
    end
  endtask

  task automatic test_abort();
    lat_min = 2; lat_max = 2;
    clear_logs();
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && hs_idx_q.size() < 5; i++)
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (hs_idx_q.size() !== 5 || model_out !== 2) begin
      bad++;
      $display("FAIL abort_setup: jobs=%0d in_flight=%0d, required 5 2", hs_idx_q.size(), model_out);
    end
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    total++;
    if (vec_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_valid: vec_valid=%b, required 0", vec_valid);
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (stat_busy !== (model_out != 0)) begin
        bad++;
        $display("FAIL abort_drain: busy=%b with %0d in flight", stat_busy, model_out);
      end
      if (stat_busy !== 1'b1) break;
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    end
    total++;
    if (stat_busy !== 1'b0 || model_out !== 0 || hs_idx_q.size() !== 5 || done_cnt !== 0 ||
        stat_err !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL abort_end: busy=%b out=%0d jobs=%0d done=%0d err=%b irq=%b, required 0 0 5 0 0 0",
               stat_busy, model_out, hs_idx_q.size(), done_cnt, stat_err, irq);
    end
  endtask

  task automatic test_back_to_back();
    lat_min = 1; lat_max = 12;
    run_seq("rand32", 3'd5, 2, 1'b1);
    lat_min = 1; lat_max = 6;
    run_seq("rand8", 3'd3, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit in_col;
    lat_min = 3; lat_max = 3;
    clear_logs();
    in_col = 1'b0;
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && !in_col; i++) begin
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      in_col = (hs_dir_q.size() > 0) && (hs_dir_q[hs_dir_q.size() - 1] == 1'b1);
    end
    total++;
    if (in_col !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_reach: column pass started=%b, required 1", in_col);
    end
    #2;
    ARESET = 1'b1;
    #1;
    total++;
    if ({vec_valid, vec_idx, vec_dir, vec_len_log2, stat_busy, stat_pass, stat_done, stat_err, irq} !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid: outputs %b, required all 0",
               {vec_valid, vec_idx, vec_dir, vec_len_log2, stat_busy, stat_pass, stat_done, stat_err, irq});
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    due_q.delete();
    model_out = 0;
    last_due = cyc;
    run_seq("post_reset4", 3'd2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_bad_size();
    test_spurious();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
